// File: rtl/sme_match_pkg.sv
// sme_match_pkg: shared constants, arbiter state type and drop-accounting
// helper for the sme_match_collector block.
//   SME_LANE_STRIDE  : bit stride of one lane on the collector input bus
//   SME_ID_OUT_WIDTH : width of the zero-extended granted rule ID
//   arb_state_e      : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   sme_popcount     : number of set bits in a 16-bit lane mask
package sme_match_pkg;

  localparam int SME_LANE_STRIDE  = 16;
  localparam int SME_ID_OUT_WIDTH = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [5:0] sme_popcount(input logic [15:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/simple_fifo.sv
// simple_fifo: single-clock FIFO of 2**ADDR_WIDTH entries with a
// show-ahead head (rd_data is always the oldest entry while not empty).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en     : push wr_data; ignored while full
//   wr_data   : entry to push
//   rd_en     : pop the head; ignored while empty
//   rd_data   : current head entry
//   full      : all entries occupied (registered state)
//   empty     : no entries occupied (registered state)
// A push and a pop in the same cycle both take effect; fullness is judged
// on the registered count, i.e. before that cycle's pop.
module simple_fifo #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sme_match_collector.sv
// sme_match_collector: collects beats of LANES rule IDs, drops zero IDs,
// buffers each lane in its own FIFO and serialises the buffered IDs onto a
// single held-until-released match port (round-robin or fixed priority).
// Optional feature macro: SME_MATCH_DROP_CNT_EN (drop_count / overflow).
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_data          : lane m ID at [m*16 +: ID_WIDTH], upper lane bits ignored
//   in_valid         : beat valid; writes happen regardless of in_ready
//   in_ready         : advisory, every lane FIFO has a free slot
//   match_rule_ID    : granted ID, zero-extended to 16 bits
//   match_valid      : grant valid, held until match_release
//   match_release    : consumer pops the current grant
//   match_valid_stat : per-lane FIFO non-empty mask
//   drop_count       : saturating count of dropped IDs (0 without macro)
//   overflow         : sticky drop flag (0 without macro)
//
// Handshake: the match port is valid/release. Once match_valid rises,
// match_rule_ID is frozen until a cycle with match_release=1 is sampled;
// that edge pops the granted lane and clears match_valid. match_release
// while match_valid=0 has no effect. The input side has no true
// handshake: in_ready is advisory and a non-zero ID offered to a full lane
// is dropped.
module sme_match_collector
  import sme_match_pkg::*;
#(
  parameter int    LANES      = 8,
  parameter int    ID_WIDTH   = 13,
  parameter int    FIFO_DEPTH = 4,
  parameter string ARB_MODE   = "ROUND_ROBIN"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SME_LANE_STRIDE*LANES-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [SME_ID_OUT_WIDTH-1:0]  match_rule_ID,
  output logic                         match_valid,
  input  logic                         match_release,
  output logic [LANES-1:0]             match_valid_stat,
  output logic [31:0]                  drop_count,
  output logic                         overflow
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam bit USE_PRIO = (ARB_MODE == "PRIORITY");

  logic [LANES-1:0]    lane_nz;
  logic [LANES-1:0]    lane_full;
  logic [LANES-1:0]    lane_empty;
  logic [LANES-1:0]    lane_wr;
  logic [LANES-1:0]    lane_drop;
  logic [LANES-1:0]    lane_pop;
  logic [ID_WIDTH-1:0] lane_id [LANES];
  logic [ID_WIDTH-1:0] head    [LANES];
  logic                unused_in_bits;

  // Only the ID bits of each lane are consumed; the rest are don't-care.
  assign unused_in_bits = ^in_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_id[g]   = in_data[g*SME_LANE_STRIDE +: ID_WIDTH];
    assign lane_nz[g]   = |lane_id[g];
    assign lane_wr[g]   = in_valid & lane_nz[g] & ~lane_full[g];
    assign lane_drop[g] = in_valid & lane_nz[g] & lane_full[g];

    simple_fifo #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (ID_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (lane_wr[g]),
      .wr_data (lane_id[g]),
      .rd_en   (lane_pop[g]),
      .rd_data (head[g]),
      .full    (lane_full[g]),
      .empty   (lane_empty[g])
    );
  end

  assign in_ready         = ~|lane_full;
  assign match_valid_stat = ~lane_empty;

  // ---------------- arbiter ----------------
  arb_state_e          state;
  arb_state_e          state_nxt;
  logic [LW-1:0]       rr_ptr;
  logic [LW-1:0]       grant_lane;
  logic [LW-1:0]       sel_lane;
  logic                sel_found;
  logic                load_grant;
  logic                do_release;
  logic [SME_ID_OUT_WIDTH-1:0] id_q;
  logic                valid_q;

  // Lane selection: round-robin scans from the lane after the last grant,
  // priority scans from lane 0. First non-empty lane in scan order wins.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_lane  = '0;
    idx       = 0;
    for (int k = 0; k < LANES; k++) begin
      if (USE_PRIO) idx = k;
      else          idx = (int'(rr_ptr) + 1 + k) % LANES;
      if (!sel_found && !lane_empty[idx]) begin
        sel_found = 1'b1;
        sel_lane  = LW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_grant = 1'b0;
    do_release = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (sel_found) begin
          load_grant = 1'b1;
          state_nxt  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (match_release) begin
          do_release = 1'b1;
          state_nxt  = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign lane_pop = do_release ? (LANES'(1) << grant_lane) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= '0;
      valid_q    <= 1'b0;
      grant_lane <= '0;
      rr_ptr     <= LW'(LANES - 1);
    end else if (load_grant) begin
      id_q       <= SME_ID_OUT_WIDTH'(head[sel_lane]);
      valid_q    <= 1'b1;
      grant_lane <= sel_lane;
      rr_ptr     <= sel_lane;
    end else if (do_release) begin
      valid_q    <= 1'b0;
    end
  end

  assign match_rule_ID = id_q;
  assign match_valid   = valid_q;

  // ---------------- drop accounting ----------------
`ifdef SME_MATCH_DROP_CNT_EN
  logic [31:0] drop_cnt_q;
  logic        overflow_q;
  logic [5:0]  drops_now;
  logic [32:0] drop_sum;

  assign drops_now = sme_popcount(16'(lane_drop));
  assign drop_sum  = {1'b0, drop_cnt_q} + 33'(drops_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Carry out of bit 31 means the true total passed 2^32-1: clamp.
      drop_cnt_q <= drop_sum[32] ? '1 : drop_sum[31:0];
      if (|lane_drop) overflow_q <= 1'b1;
    end
  end

  assign drop_count = drop_cnt_q;
  assign overflow   = overflow_q;
`else
  logic unused_drop;
  assign unused_drop = ^lane_drop;
  assign drop_count  = '0;
  assign overflow    = 1'b0;
`endif

endmodule
